reward_placer: RTL and testbench

- Consumer stage directly downstream of the reward random generator.
- Takes each candidate reward (position and type) while the generator holds set_require.
- Checks the candidate against snake-body occupancy and publishes a valid reward to the renderer and collision logic.
- Detects the snake head eating the reward, issues score and grow pulses, keeps a saturating score total, and returns set_finish to close the generator episode.

---
 rtl/reward_placer.sv | 118 +++++++++++
 tb/tb_reward_placer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reward_placer.sv
// reward_placer: takes reward candidates from the random generator, checks them
// against snake-body occupancy, publishes valid rewards and scores head eats.
// Ports:
//   clk, rst_n (async active-low), clear (sync restart: IDLE, score_total=0)
//   set_require/reward_type/random_xpos/random_ypos : generator candidate
//   set_finish       : level back to the generator, episode done
//   query_req/x/y    : one-cycle occupancy lookup; query_hit answers 1 clk later
//   head_valid/x/y   : snake step pulse with new head position
//   reward_valid/x/y/kind : reward currently on the board
//   score_add/grow   : one-cycle eat pulses; score_total saturates at SCORE_MAX
//   reject_cnt       : candidates dropped on collision (wraps)
module reward_placer #(
    parameter int POS_W     = 6,
    parameter int PTS_T1    = 1,
    parameter int PTS_T2    = 2,
    parameter int PTS_T3    = 5,
    parameter int SCORE_MAX = 999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             set_require,
    input  logic [1:0]       reward_type,
    input  logic [POS_W-1:0] random_xpos,
    input  logic [POS_W-1:0] random_ypos,
    output logic             set_finish,
    output logic             query_req,
    output logic [POS_W-1:0] query_x,
    output logic [POS_W-1:0] query_y,
    input  logic             query_hit,
    input  logic             head_valid,
    input  logic [POS_W-1:0] head_x,
    input  logic [POS_W-1:0] head_y,
    output logic             reward_valid,
    output logic [POS_W-1:0] reward_x,
    output logic [POS_W-1:0] reward_y,
    output logic [1:0]       reward_kind,
    output logic [3:0]       score_add,
    output logic             grow,
    output logic [9:0]       score_total,
    output logic [7:0]       reject_cnt
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] QUERY  = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] ACTIVE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]       state, state_n;
    logic [POS_W-1:0] lx, ly, lx_n, ly_n;
    logic [1:0]       lt, lt_n;
    logic             load, eat;
    logic [3:0]       pts;
    logic [10:0]      sum;

    // The generator's position lags its request, so x==0 means "not ready yet".
    assign load = state == IDLE && !clear && set_require && random_xpos != '0;
    assign eat  = state == ACTIVE && !clear && head_valid && head_x == lx && head_y == ly;
    assign lx_n = load ? random_xpos : lx;
    assign ly_n = load ? random_ypos : ly;
    assign lt_n = load ? reward_type : lt;
    assign pts  = lt == 2'd1 ? 4'(PTS_T1) : lt == 2'd2 ? 4'(PTS_T2) : lt == 2'd3 ? 4'(PTS_T3) : 4'd0;
    assign sum  = 11'(score_total) + 11'(pts);

    always_comb begin
        state_n = state;
        if (clear)
            state_n = IDLE;
        else
            case (state)
                IDLE:    if (load) state_n = reward_type == 2'd0 ? DONE : QUERY;
                QUERY:   state_n = WAIT;
                WAIT:    state_n = query_hit ? DONE : ACTIVE;
                ACTIVE:  state_n = eat ? DONE : (set_require ? ACTIVE : IDLE);
                DONE:    state_n = set_require ? DONE : IDLE;
                default: state_n = IDLE;
            endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lx           <= '0;
            ly           <= '0;
            lt           <= '0;
            set_finish   <= 1'b0;
            query_req    <= 1'b0;
            query_x      <= '0;
            query_y      <= '0;
            reward_valid <= 1'b0;
            reward_x     <= '0;
            reward_y     <= '0;
            reward_kind  <= '0;
            score_add    <= '0;
            grow         <= 1'b0;
            score_total  <= '0;
            reject_cnt   <= '0;
        end else begin
            state        <= state_n;
            lx           <= lx_n;
            ly           <= ly_n;
            lt           <= lt_n;
            set_finish   <= state_n == DONE;
            query_req    <= state_n == QUERY;
            query_x      <= state_n == QUERY ? lx_n : '0;
            query_y      <= state_n == QUERY ? ly_n : '0;
            reward_valid <= state_n == ACTIVE;
            reward_x     <= state_n == ACTIVE ? lx_n : '0;
            reward_y     <= state_n == ACTIVE ? ly_n : '0;
            reward_kind  <= state_n == ACTIVE ? lt_n : '0;
            score_add    <= eat ? pts : 4'd0;
            grow         <= eat;
            score_total  <= clear ? 10'd0 : eat ? (sum > 11'(SCORE_MAX) ? 10'(SCORE_MAX) : sum[9:0]) : score_total;
            reject_cnt   <= reject_cnt + 8'(state == WAIT && !clear && query_hit);
        end
    end
endmodule

// File: tb/tb_reward_placer.sv
// tb_reward_placer: directed and randomized bench for reward_placer against a behavioural model.
module tb_reward_placer;
    localparam int POS_W = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             clear = 1'b0;
    logic             set_require = 1'b0;
    logic [1:0]       reward_type = '0;
    logic [POS_W-1:0] random_xpos = '0;
    logic [POS_W-1:0] random_ypos = '0;
    logic             query_hit = 1'b0;
    logic             head_valid = 1'b0;
    logic [POS_W-1:0] head_x = '0;
    logic [POS_W-1:0] head_y = '0;
    logic             set_finish, query_req, reward_valid, grow;
    logic [POS_W-1:0] query_x, query_y, reward_x, reward_y;
    logic [1:0]       reward_kind;
    logic [3:0]       score_add;
    logic [9:0]       score_total;
    logic [7:0]       reject_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reward_placer dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .set_require(set_require),
        .reward_type(reward_type), .random_xpos(random_xpos), .random_ypos(random_ypos),
        .set_finish(set_finish), .query_req(query_req), .query_x(query_x), .query_y(query_y),
        .query_hit(query_hit), .head_valid(head_valid), .head_x(head_x), .head_y(head_y),
        .reward_valid(reward_valid), .reward_x(reward_x), .reward_y(reward_y),
        .reward_kind(reward_kind), .score_add(score_add), .grow(grow),
        .score_total(score_total), .reject_cnt(reject_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: episode phase 0 idle, 1 query, 2 wait-result, 3 shown, 4 finished.
    int pts_of[4] = '{0, 1, 2, 5};
    int ph, mx, my, mt, msc, mrej, madd, mgrow;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0; mx = 0; my = 0; mt = 0; msc = 0; mrej = 0; madd = 0; mgrow = 0;
        end else begin
            madd = 0;
            mgrow = 0;
            if (clear) begin
                ph = 0;
                msc = 0;
            end else if (ph == 0) begin
                if (set_require && random_xpos != 0) begin
                    mx = int'(random_xpos); my = int'(random_ypos); mt = int'(reward_type);
                    ph = (mt == 0) ? 4 : 1;
                end
            end else if (ph == 1) begin
                ph = 2;
            end else if (ph == 2) begin
                if (query_hit) begin mrej = (mrej + 1) % 256; ph = 4; end
                else ph = 3;
            end else if (ph == 3) begin
                if (head_valid && int'(head_x) == mx && int'(head_y) == my) begin
                    madd = pts_of[mt];
                    mgrow = 1;
                    msc = (msc + madd > 999) ? 999 : msc + madd;
                    ph = 4;
                end else if (!set_require) ph = 0;
            end else if (!set_require) begin
                ph = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("query_req", query_req, ph == 1);
        if (ph == 1) begin
            chk("query_x", query_x, mx);
            chk("query_y", query_y, my);
        end
        chk("reward_valid", reward_valid, ph == 3);
        if (ph == 3) begin
            chk("reward_x", reward_x, mx);
            chk("reward_y", reward_y, my);
            chk("reward_kind", reward_kind, mt);
        end
        chk("set_finish", set_finish, ph == 4);
        chk("score_add", score_add, madd);
        chk("grow", grow, mgrow);
        chk("score_total", score_total, msc);
        chk("reject_cnt", reject_cnt, mrej);
    end

    // Occupancy responder: answers the cycle after a lookup; junk otherwise.
    int  hit_mode = 0;
    logic qr_seen = 1'b0;
    always @(negedge clk) qr_seen = query_req;
    always @(posedge clk) begin
        #2;
        query_hit = qr_seen ? (hit_mode == 1 || (hit_mode == 2 && $urandom_range(0, 3) == 0)) : 1'($urandom_range(0, 1));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Drives an episode up to the point where the reward is shown (or rejected).
    task automatic start_episode(input int x, input int y, input int t);
        set_require = 1'b1;
        random_xpos = '0;
        step(2);
        random_xpos = POS_W'(x);
        random_ypos = POS_W'(y);
        reward_type = 2'(t);
        step(3);
    endtask

    task automatic eat_and_close(input int x, input int y);
        head_valid = 1'b1;
        head_x = POS_W'(x);
        head_y = POS_W'(y);
        step(1);
        head_valid = 1'b0;
        set_require = 1'b0;
        random_xpos = '0;
        step(2);
    endtask

    int lag = 0;
    int cx = 1, cy = 0;

    initial begin
        #1 rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("lit_reset_score", score_total, 0);
        chk("lit_reset_rej", reject_cnt, 0);
        chk("lit_reset_valid", reward_valid, 0);

        // Normal eat
        set_require = 1'b1;
        step(2);
        random_xpos = 6'd4; random_ypos = 6'd2; reward_type = 2'd2;
        step(1);
        chk("lit_qreq", query_req, 1);
        chk("lit_qx", query_x, 4);
        chk("lit_qy", query_y, 2);
        step(2);
        chk("lit_valid", reward_valid, 1);
        chk("lit_rx", reward_x, 4);
        chk("lit_kind", reward_kind, 2);
        head_valid = 1'b1; head_x = 6'd4; head_y = 6'd2;
        step(1);
        head_valid = 1'b0;
        chk("lit_add", score_add, 2);
        chk("lit_grow", grow, 1);
        chk("lit_total", score_total, 2);
        chk("lit_finish", set_finish, 1);
        step(1);
        chk("lit_add_once", score_add, 0);
        chk("lit_finish_held", set_finish, 1);
        set_require = 1'b0; random_xpos = '0;
        step(1);
        chk("lit_finish_drop", set_finish, 0);

        // Collision reject
        hit_mode = 1;
        start_episode(10, 5, 1);
        chk("lit_rej", reject_cnt, 1);
        chk("lit_rej_valid", reward_valid, 0);
        chk("lit_rej_finish", set_finish, 1);
        set_require = 1'b0; random_xpos = '0;
        step(1);
        chk("lit_rej_drop", set_finish, 0);
        hit_mode = 0;

        // Timeout
        start_episode(9, 9, 1);
        chk("lit_to_valid", reward_valid, 1);
        set_require = 1'b0; random_xpos = '0;
        step(1);
        chk("lit_to_gone", reward_valid, 0);
        chk("lit_to_finish", set_finish, 0);
        chk("lit_to_score", score_total, 2);
        step(1);

        // Simultaneous eat and timeout
        start_episode(20, 30, 3);
        head_valid = 1'b1; head_x = 6'd20; head_y = 6'd30;
        set_require = 1'b0; random_xpos = '0;
        step(1);
        head_valid = 1'b0;
        chk("lit_sim_add", score_add, 5);
        chk("lit_sim_grow", grow, 1);
        chk("lit_sim_total", score_total, 7);
        chk("lit_sim_done", set_finish, 1);
        step(1);
        chk("lit_sim_idle", set_finish, 0);

        // Saturation
        for (int i = 0; i < 198; i++) begin
            start_episode(1 + i % 60, i % 64, 3);
            eat_and_close(1 + i % 60, i % 64);
        end
        chk("lit_pre", score_total, 997);
        start_episode(33, 44, 3);
        eat_and_close(33, 44);
        chk("lit_sat", score_total, 999);
        start_episode(5, 6, 1);
        eat_and_close(5, 6);
        chk("lit_sat_hold", score_total, 999);

        // Clear while ACTIVE
        start_episode(12, 13, 2);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("lit_clr_valid", reward_valid, 0);
        chk("lit_clr_score", score_total, 0);
        chk("lit_clr_rej", reject_cnt, 1);
        set_require = 1'b0; random_xpos = '0;
        step(3);

        // Async reset mid-ACTIVE, then restart with request already up
        start_episode(7, 3, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("lit_ar_valid", reward_valid, 0);
        chk("lit_ar_rx", reward_x, 0);
        chk("lit_ar_rej", reject_cnt, 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("lit_ar_qreq", query_req, 1);
        chk("lit_ar_qx", query_x, 7);
        chk("lit_ar_qy", query_y, 3);
        step(2);
        set_require = 1'b0; random_xpos = '0;
        step(2);

        // Randomized traffic
        hit_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            if (!set_require) begin
                if ($urandom_range(0, 3) == 0) begin
                    set_require = 1'b1;
                    lag = 2;
                end
            end else if (lag > 0) begin
                lag--;
                if (lag == 0) begin
                    cx = $urandom_range(1, 63);
                    cy = $urandom_range(0, 63);
                    random_xpos = POS_W'(cx);
                    random_ypos = POS_W'(cy);
                    reward_type = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
                end
            end else if (set_finish ? $urandom_range(0, 2) == 0 : $urandom_range(0, 40) == 0) begin
                set_require = 1'b0;
                random_xpos = '0;
            end else if ($urandom_range(0, 15) == 0) begin
                random_xpos = POS_W'($urandom_range(1, 63));
                random_ypos = POS_W'($urandom_range(0, 63));
                reward_type = 2'($urandom_range(0, 3));
            end
            head_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                head_x = POS_W'(cx);
                head_y = POS_W'(cy);
            end else begin
                head_x = POS_W'($urandom_range(0, 63));
                head_y = POS_W'($urandom_range(0, 63));
            end
            clear = ($urandom_range(0, 60) == 0);
            step(1);
        end
        clear = 1'b0;
        head_valid = 1'b0;
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
